// File: rtl/btb_update_ctrl.sv
// BTB update controller: queues resolved-branch updates and performs a
// read-merge-write on the BTB array, sharing its read port with fetch.
module btb_update_ctrl #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         upd_valid,
  output logic         upd_ready,
  input  logic [31:0]  upd_pc,
  input  logic [31:0]  upd_target,
  input  logic         upd_mispredicted,
  input  logic         fetch_rd_en,
  input  logic [2:0]   fetch_index,
  output logic         fetch_grant,
  output logic         arr_rd_en,
  output logic [2:0]   arr_rd_index,
  input  logic [127:0] arr_rd_data,
  output logic         arr_wr_en,
  output logic [2:0]   arr_wr_index,
  output logic [127:0] arr_wr_set,
  output logic [127:0] wrl_update_set,
  output logic [26:0]  wrl_tag,
  output logic [2:0]   wrl_index,
  output logic [31:0]  wrl_target,
  output logic         wrl_mispredicted,
  input  logic [127:0] wrl_write_set,
  input  logic         wrl_next_lru,
  output logic [7:0]   lru,
  output logic         busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [26:0] tag;
    logic [2:0]  idx;
    logic [31:0] tgt;
    logic        mp;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StRead, StWait, StWrite} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;
  entry_t          fifo_q [FIFO_DEPTH];
  logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count;
  logic [127:0]    set_q;
  logic [7:0]      lru_q;
  logic            empty, full, push, pop, own;
  entry_t          head, in_entry;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign upd_ready = ~full;
  assign push      = upd_valid & ~full;
  assign head      = fifo_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    in_entry.tag = upd_pc[31:5];
    in_entry.idx = upd_pc[4:2];
    in_entry.tgt = upd_target;
    in_entry.mp  = upd_mispredicted;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q[PtrW-1:0]] <= in_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = '0;
    own      = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) state_d = StRead;
      end
      StRead: begin
        // Take the port when fetch is idle or has been favoured long enough.
        if (!fetch_rd_en || (starve_q == CntW'(STARVE_LIMIT))) begin
          own     = 1'b1;
          state_d = StWait;
        end else begin
          starve_d = starve_q + CntW'(1);
        end
      end
      StWait: begin
        state_d = StWrite;
      end
      StWrite: begin
        pop     = 1'b1;
        state_d = ((count > (PtrW + 1)'(1)) || push) ? StRead : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_q <= '0;
    end else if (state_q == StWait) begin
      set_q <= arr_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru_q <= '0;
    end else if (state_q == StWrite) begin
      lru_q[head.idx] <= wrl_next_lru;
    end
  end

  always_comb begin
    arr_rd_en        = own ? 1'b1 : fetch_rd_en;
    arr_rd_index     = own ? head.idx : fetch_index;
    fetch_grant      = own ? 1'b0 : fetch_rd_en;
    arr_wr_en        = (state_q == StWrite);
    arr_wr_index     = head.idx;
    arr_wr_set       = wrl_write_set;
    wrl_update_set   = set_q;
    wrl_tag          = head.tag;
    wrl_index        = head.idx;
    wrl_target       = head.tgt;
    wrl_mispredicted = head.mp;
    lru              = lru_q;
    busy             = (state_q != StIdle) || !empty;
  end

endmodule
